// File: rtl/dmem_access_ctrl.sv
// Stage 3 data-memory sequencer: issues one dcache request per load/store and stalls
// the pipeline until it completes; a saturating watchdog flags accesses that hang.
module dmem_access_ctrl #(
  parameter int AWIDTH  = 32,
  parameter int DWIDTH  = 32,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_valid,
  input  logic              mem_re,
  input  logic [3:0]        mem_we,
  input  logic [AWIDTH-1:0] mem_addr,
  input  logic [DWIDTH-1:0] mem_wdata,
  output logic              dcache_req_valid,
  input  logic              dcache_req_ready,
  output logic [AWIDTH-3:0] dcache_addr,
  output logic [DWIDTH-1:0] dcache_din,
  output logic [3:0]        dcache_we,
  input  logic              dcache_resp_valid,
  input  logic [DWIDTH-1:0] dcache_resp_data,
  output logic              stall,
  output logic              ld_valid,
  output logic [DWIDTH-1:0] ld_data,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  // err is registered, so it is set one edge early to be visible in the TIMEOUT-th outstanding cycle
  localparam logic [CNT_W-1:0] ERR_AT  = CNT_W'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [AWIDTH-3:0]   addr_q, addr_d;
  logic [DWIDTH-1:0]   din_q, din_d;
  logic [3:0]          we_q, we_d;
  logic                is_load_q, is_load_d;
  logic [DWIDTH-1:0]   ld_data_q, ld_data_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                op;
  logic                unused_addr_lsbs;

  assign unused_addr_lsbs = ^mem_addr[1:0];
  assign op = mem_valid & (mem_re | (mem_we != 4'b0000));

  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    din_d            = din_q;
    we_d             = we_q;
    is_load_d        = is_load_q;
    ld_data_d        = ld_data_q;
    cnt_d            = cnt_q;
    err_d            = err_q;
    stall            = 1'b0;
    dcache_req_valid = 1'b0;
    ld_valid         = 1'b0;

    unique case (state_q)
      IDLE: begin
        stall = op;
        if (op) begin
          addr_d    = mem_addr[AWIDTH-1:2];
          din_d     = mem_wdata;
          we_d      = mem_we;
          is_load_d = mem_re & (mem_we == 4'b0000);
          cnt_d     = '0;
          state_d   = REQ;
        end
      end
      REQ: begin
        stall            = 1'b1;
        dcache_req_valid = 1'b1;
        if (dcache_req_ready) state_d = is_load_q ? RESP : DONE;
      end
      RESP: begin
        stall = 1'b1;
        if (dcache_resp_valid) begin
          ld_data_d = dcache_resp_data;
          state_d   = DONE;
        end
      end
      DONE: begin
        ld_valid = is_load_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_q == REQ || state_q == RESP) begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      if (cnt_d >= ERR_AT) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      din_q     <= '0;
      we_q      <= '0;
      is_load_q <= 1'b0;
      ld_data_q <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      we_q      <= we_d;
      is_load_q <= is_load_d;
      ld_data_q <= ld_data_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  assign dcache_addr = addr_q;
  assign dcache_din  = din_q;
  assign dcache_we   = we_q;
  assign ld_data     = ld_data_q;
  assign err         = err_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: directed scenarios with literal expectations, then random
// instructions, all checked every cycle against a transaction-level model.
module tb_dmem_access_ctrl;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_valid = 1'b0, mem_re = 1'b0;
  logic [3:0]  mem_we = 4'h0;
  logic [31:0] mem_addr = '0, mem_wdata = '0;
  logic        req_ready = 1'b0, resp_valid = 1'b0;
  logic [31:0] resp_data = '0;
  logic        dcache_req_valid, stall, ld_valid, err;
  logic [29:0] dcache_addr;
  logic [31:0] dcache_din, ld_data;
  logic [3:0]  dcache_we;

  int checks = 0, errors = 0;

  dmem_access_ctrl #(.AWIDTH(32), .DWIDTH(32), .TIMEOUT(TO), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_re(mem_re), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .dcache_req_valid(dcache_req_valid),
    .dcache_req_ready(req_ready), .dcache_addr(dcache_addr), .dcache_din(dcache_din),
    .dcache_we(dcache_we), .dcache_resp_valid(resp_valid), .dcache_resp_data(resp_data),
    .stall(stall), .ld_valid(ld_valid), .ld_data(ld_data), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit op_now();
    return mem_valid && (mem_re || mem_we != 4'h0);
  endfunction

  // Transaction model: one access in flight, split into "waiting for accept" and
  // "waiting for data", followed by a single completion cycle.
  bit          m_busy, m_acc, m_done, m_load, m_err, cmp_en;
  logic [29:0] m_addr = '0;
  logic [31:0] m_din = '0, m_ld = '0;
  logic [3:0]  m_we = '0;
  int          m_outs;

  initial forever begin
    @(posedge clk);
    if (reset) begin
      m_busy = 0; m_acc = 0; m_done = 0; m_load = 0; m_err = 0;
      m_addr = '0; m_din = '0; m_we = '0; m_ld = '0; m_outs = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (!m_busy) begin
      if (op_now()) begin
        m_busy = 1; m_acc = 0; m_outs = 0;
        m_addr = mem_addr[31:2]; m_din = mem_wdata; m_we = mem_we;
        m_load = (mem_we == 4'h0);
      end
    end else begin
      m_outs++;
      // err must be visible from the TO-th outstanding cycle onward
      if (m_outs + 1 >= TO) m_err = 1;
      if (!m_acc) begin
        if (req_ready) begin
          if (m_load) m_acc = 1;
          else begin m_busy = 0; m_done = 1; end
        end
      end else if (resp_valid) begin
        m_ld = resp_data; m_busy = 0; m_done = 1;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      chk("stall", stall, m_busy ? 1 : (m_done ? 0 : op_now()));
      chk("req_valid", dcache_req_valid, m_busy && !m_acc);
      chk("ld_valid", ld_valid, m_done && m_load);
      chk("ld_data", ld_data, m_ld);
      chk("err", err, m_err);
      chk("dc_addr", dcache_addr, m_addr);
      chk("dc_din", dcache_din, m_din);
      chk("dc_we", dcache_we, m_we);
    end
  end

  int n, reqc, k;
  bit sl;

  initial begin
    step(); step();
    reset = 0; cmp_en = 1;
    @(negedge clk);
    chk("rst_stall", stall, 0);    chk("rst_req", dcache_req_valid, 0);
    chk("rst_ld_valid", ld_valid, 0); chk("rst_ld_data", ld_data, 0);
    chk("rst_err", err, 0);        chk("rst_addr", dcache_addr, 0);
    chk("rst_din", dcache_din, 0); chk("rst_we", dcache_we, 0);

    // store with immediate accept
    step();
    mem_valid = 1; mem_re = 0; mem_we = 4'hF; mem_addr = 32'h1000_0008;
    mem_wdata = 32'hDEAD_BEEF; req_ready = 1;
    @(negedge clk); chk("st_idle_stall", stall, 1); chk("st_idle_req", dcache_req_valid, 0);
    step();
    @(negedge clk);
    chk("st_req", dcache_req_valid, 1); chk("st_addr", dcache_addr, 30'h0400_0002);
    chk("st_din", dcache_din, 32'hDEAD_BEEF); chk("st_we", dcache_we, 4'hF);
    step();
    @(negedge clk); chk("st_done_stall", stall, 0); chk("st_done_ldv", ld_valid, 0);
    step(); mem_valid = 0; mem_we = 0;

    // load with response in the third RESP cycle
    step();
    mem_valid = 1; mem_re = 1; mem_we = 0; mem_addr = 32'h0000_0100;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (!stall) break;
      n++;
      step();
      resp_valid = (n == 4);
      resp_data = (n == 4) ? 32'h1234_5678 : 32'h0;
    end
    chk("ld_stall_cycles", n, 5); chk("ld_done_valid", ld_valid, 1);
    chk("ld_done_data", ld_data, 32'h1234_5678);
    step(); mem_valid = 0; mem_re = 0; resp_valid = 0;

    // accept held off for four REQ cycles
    step();
    mem_valid = 1; mem_we = 4'h3; mem_addr = 32'h0000_2004; mem_wdata = 32'hA5A5_5A5A; req_ready = 0;
    reqc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!stall) break;
      if (dcache_req_valid) begin
        reqc++;
        chk("bp_addr", dcache_addr, 30'h801); chk("bp_we", dcache_we, 4'h3);
      end
      step();
      req_ready = (reqc == 4);
    end
    chk("bp_req_cycles", reqc, 5);
    step(); mem_valid = 0; mem_we = 0; req_ready = 1;

    // load then store back to back; response line held high throughout
    step();
    mem_valid = 1; mem_re = 1; mem_we = 0; mem_addr = 32'h40;
    resp_valid = 1; resp_data = 32'hCAFE_F00D;
    reqc = 0; k = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (dcache_req_valid) reqc++;
      sl = stall;
      step();
      if (!sl) begin
        if (k == 0) begin
          mem_re = 0; mem_we = 4'hF; mem_addr = 32'h44; mem_wdata = 32'h1122_3344;
        end else mem_valid = 0;
        k++;
      end
    end
    @(negedge clk);
    chk("b2b_requests", reqc, 2); chk("b2b_ld_data", ld_data, 32'hCAFE_F00D);
    step(); resp_valid = 0; mem_we = 0;

    // watchdog: response arrives long after TIMEOUT
    step();
    mem_valid = 1; mem_re = 1; mem_addr = 32'h80; req_ready = 1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!stall) break;
      if (i == 7) chk("wd_err_cycle7", err, 0);
      if (i == 8) chk("wd_err_cycle8", err, 1);
      n++;
      step();
      resp_valid = (i + 1 == 12);
      resp_data = 32'h0BAD_CAFE;
    end
    chk("wd_cycles", n, 13); chk("wd_err_done", err, 1);
    chk("wd_ld_valid", ld_valid, 1); chk("wd_ld_data", ld_data, 32'h0BAD_CAFE);
    step(); mem_valid = 0; mem_re = 0; resp_valid = 0; reset = 1;
    @(negedge clk); chk("wd_err_sticky", err, 1);
    step(); reset = 0;
    @(negedge clk); chk("wd_err_cleared", err, 0);

    // reset while waiting for data, then a stray response
    step();
    mem_valid = 1; mem_re = 1; mem_addr = 32'h200;
    step(); step();
    reset = 1; mem_valid = 0; mem_re = 0;
    @(negedge clk); chk("rm_resp_stall", stall, 1);
    step(); reset = 0; resp_valid = 1; resp_data = 32'hBAD0_BAD0;
    @(negedge clk);
    chk("rm_stall", stall, 0); chk("rm_err", err, 0); chk("rm_ld_valid", ld_valid, 0);
    step(); resp_valid = 0;
    @(negedge clk); chk("rm_late_ldv", ld_valid, 0); chk("rm_late_data", ld_data, 0);

    // random instructions, handshakes and occasional resets
    sl = 0;
    for (int c = 0; c < 3000; c++) begin
      step();
      reset = ($urandom_range(0, 99) == 0);
      req_ready = ($urandom_range(0, 2) != 0);
      resp_valid = ($urandom_range(0, 2) == 0);
      resp_data = $urandom();
      if (!sl) begin
        mem_valid = ($urandom_range(0, 3) != 0);
        mem_re = 1'($urandom_range(0, 1));
        mem_we = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 15)) : 4'h0;
        mem_addr = $urandom();
        mem_wdata = $urandom();
      end
      @(negedge clk);
      sl = stall;
    end
    step(); cmp_en = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Sequences every Stage 3 data-memory access (load or store) onto the data cache request/response handshake.
- Holds the pipeline with `stall` until the access completes, then presents the returned load word to the write-back mux for one cycle.
- Sits between the Stage 3 memory-control decode (read enable, 4-bit write mask) and the dcache port.
- Includes a saturating watchdog that flags hung accesses.

Parameters:
- AWIDTH, 32, byte address width.
- DWIDTH, 32, data word width.
- TIMEOUT, 1024, cycles an access may stay outstanding before `err` is set; must be ≥2.
- CNT_W, 11, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_valid  in  1  Stage 3 holds a valid instruction this cycle.
- mem_re  in  1  instruction is a load.
- mem_we  in  4  byte write mask; nonzero means store.
- mem_addr  in  AWIDTH  byte address from ALU.
- mem_wdata  in  DWIDTH  store data, already lane-shifted.
- dcache_req_valid  out  1  request valid.
- dcache_req_ready  in  1  cache accepts request.
- dcache_addr  out  AWIDTH-2  word address, equal to latched addr[AWIDTH-1:2].
- dcache_din  out  DWIDTH  latched store data.
- dcache_we  out  4  latched mask; 0 for loads.
- dcache_resp_valid  in  1  load data valid.
- dcache_resp_data  in  DWIDTH  load data.
- stall  out  1  freeze PC and pipeline registers this cycle.
- ld_valid  out  1  ld_data holds the completed load word.
- ld_data  out  DWIDTH  registered load word (full word; extraction is done downstream).
- err  out  1  sticky watchdog error.

Behaviour:
- Reset values: state=IDLE; dcache_req_valid=0; dcache_we=0; dcache_addr=0; dcache_din=0; stall=0; ld_valid=0; ld_data=0; err=0; watchdog counter=0.
- Definition: op = mem_valid & (mem_re | (mem_we != 0)).
- If mem_re and mem_we are both nonzero, the access is treated as a store and mem_re is ignored.
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE:
  - stall = op, combinational.
  - On op: latch addr, wdata, we, and is_load = mem_re & (mem_we == 0); go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - dcache_req_valid=1 with latched fields; stall=1.
  - On dcache_req_ready: a store goes to DONE; a load goes to RESP.
  - Fields must stay stable while valid & !ready.
- RESP:
  - dcache_req_valid=0; stall=1.
  - On dcache_resp_valid: ld_data <= dcache_resp_data; go to DONE.
- DONE:
  - stall=0; ld_valid=1 for a load, 0 for a store; dcache_req_valid=0.
  - Inputs are ignored, since they still show the same stalled instruction.
  - Next state is always IDLE.
- Latency: minimum store = 3 cycles (IDLE, REQ with ready, DONE). Minimum load = 4 cycles (resp_valid in the first RESP cycle). stall is high for all cycles except DONE.
- dcache_resp_valid outside RESP is ignored; it does not change ld_data and does not set err.
- ld_valid is high only in DONE. ld_data holds its value until the next load completes.
- Watchdog:
  - The counter clears on entry to REQ and increments each cycle in REQ or RESP, saturating at its maximum.
  - When the counter reaches TIMEOUT, err <= 1. err is sticky until reset.
  - The FSM keeps waiting; err does not abort the access.
- Reset asserted in any state returns to IDLE at the next edge, abandons the outstanding access, and clears err. A late response after reset is ignored.
- The dcache_addr low two bits are dropped. Misalignment is not checked here.

Test Plan:
- Store: mem_valid=1, mem_we=4'b1111, addr=0x1000_0008, wdata=0xDEADBEEF, ready=1 in first REQ cycle -> stall high 2 cycles; one REQ cycle with dcache_addr=0x0400_0002, din=0xDEADBEEF, we=1111; DONE with stall=0, ld_valid=0.
- Load with delayed response: mem_re=1, addr=0x0000_0100, ready=1, resp_valid 3 cycles later with data 0x12345678 -> stall high 5 cycles, dcache_we=0, ld_valid=1 and ld_data=0x12345678 in DONE.
- Ready backpressure: ready held low 4 cycles in REQ -> req_valid held high with addr/din/we stable all 5 REQ cycles; stall high throughout.
- Back-to-back: load then store on consecutive instructions -> exactly one request per instruction; no request issued in DONE; second op starts in IDLE the cycle after DONE.
- Watchdog: TIMEOUT=8, load accepted, no response -> err=1 on the 8th outstanding cycle and stays 1; a later resp completes normally with err still 1; reset clears it.
- Reset mid-access: reset in RESP -> next cycle IDLE, stall=0, err=0; a stray resp_valid that follows leaves ld_valid=0 and ld_data unchanged.
